wr_ptr_full_ctrl: RTL
=====================

# wr_ptr_full_ctrl

Write-side pointer controller for the asynchronous FIFO. Qualifies push requests, owns the binary write pointer, and produces the registered Gray write pointer that is sent to the read domain. Compares against the already-synchronised read Gray pointer to produce Full, Almost_full, fill level and an overflow pulse. Sits entirely in the write clock domain, between the producer and the FIFO memory and pointer synchroniser.

## Interface
- Addr_width, 4: memory address bits; depth = 2^Addr_width; pointers are Addr_width+1 bits.
- Almost_full_thr, 12: fill level at or above which Almost_full asserts; legal range 1..2^Addr_width.
- CLK  in  1  write-domain clock; all state on rising edge.
- RST  in  1  reset, synchronous, active-high.
- W_INC  in  1  push request from producer.
- Rd_gray_sync  in  Addr_width+1  read Gray pointer, already synchronised into CLK domain.
- W_en  out  1  memory write strobe = W_INC & ~Full & ~RST (combinational).
- W_addr  out  Addr_width  memory write address = low Addr_width bits of binary write pointer.
- Wr_gray_ptr  out  Addr_width+1  registered Gray write pointer, to read-domain synchroniser.
- Full  out  1  registered; FIFO holds 2^Addr_width entries.
- Almost_full  out  1  registered; Fill_level >= Almost_full_thr.
- Fill_level  out  Addr_width+1  registered; write binary minus read binary, modulo 2^(Addr_width+1).
- Overflow  out  1  registered one-cycle pulse: W_INC seen while Full.

## Operation
- State: wbin (binary pointer), Wr_gray_ptr, Full, Almost_full, Fill_level, Overflow.
- Each cycle: wbin_next = wbin + W_en, wrapping at 2^(Addr_width+1); wgray_next = Binary2Gray(wbin_next); rbin = Gray2Binary(Rd_gray_sync).
- Registered updates: wbin <= wbin_next; Wr_gray_ptr <= wgray_next; Fill_level <= wbin_next - rbin; Full <= (wgray_next == {~Rd_gray_sync[top:top-1], Rd_gray_sync[top-2:0]}); Almost_full <= (wbin_next - rbin) >= Almost_full_thr; Overflow <= W_INC & Full.
- Invariant: Full == (Fill_level == 2^Addr_width), every cycle.
- Push while Full: no pointer change, no memory write, Overflow pulses next cycle, Full holds.
- Pointer wrap: wbin rolls 2^(Addr_width+1)-1 -> 0; Gray changes exactly one bit; W_addr wraps 2^Addr_width-1 -> 0.
- Read pointer advancing: Full/Almost_full/Fill_level are pessimistic; they release on the cycle after the new Rd_gray_sync value is sampled, never before.
- Simultaneous push and read-pointer advance in one cycle: both counted; Fill_level unchanged, Full unchanged if already below depth.
- Rd_gray_sync is trusted as a valid Gray code; no checking.

## Timing
- Reset values (RST high at an edge): wbin 0, Wr_gray_ptr 0, Full 0, Almost_full 0, Fill_level 0, Overflow 0; W_en forced 0 while RST is high.
- Reset mid-operation: all state cleared on that edge regardless of W_INC or Rd_gray_sync; the push in the RST cycle is dropped.
- Latency: push accepted at edge N -> W_addr, Wr_gray_ptr, Fill_level, Full, Almost_full reflect it after edge N.
- W_en is combinational from W_INC and registered Full; the memory writes at W_addr on the same edge.
- Full-throughput: one push per cycle until Full.

## Structure
- Shared FIFO package/header: pointer width (Addr_width+1), depth constant, default Almost_full_thr.
- Instantiate the existing Binary2Gray for wgray_next.
- New sub-module Gray2Binary (parametrised Addr_width+1, XOR prefix chain from MSB); reused later by the read-side controller.
- Everything else is flat in wr_ptr_full_ctrl.

## Test plan
Addr_width=4 (depth 16), Almost_full_thr=12, Rd_gray_sync held at 0 unless stated.
- Reset: RST 2 cycles with W_INC=1 -> all outputs 0, W_en 0, no write.
- Fill: 16 consecutive pushes -> W_addr 0..15; Almost_full rises after push 12; Full and Fill_level=16 after push 16; Wr_gray_ptr = 5'b11000.
- Overflow: 17th push while Full -> W_en 0, Overflow pulses for 1 cycle, wbin stays 16.
- Drain release: Rd_gray_sync steps to Gray(4)=5'b00110 -> next cycle Full 0, Fill_level 12, Almost_full 1; after Gray(5)=5'b00111 -> Fill_level 11, Almost_full 0.
- Wrap: with the read pointer tracking, 40 pushes -> wbin wraps 31 -> 0, W_addr wraps 15 -> 0, every Wr_gray_ptr step changes exactly one bit.
- Reset mid-fill: RST after 9 pushes with W_INC held -> all state 0 next cycle, pushes resume at W_addr 0 after RST drops.

Source files
------------

// File: rtl/wr_ptr_full_ctrl_pkg.sv
// Shared async-FIFO constants: pointer width, depth and the default almost-full threshold.
package wr_ptr_full_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned AF_THR_DEF     = 12;

  // Pointers carry one extra bit so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/wr_ptr_full_ctrl_bin2gray.sv
// Binary to reflected Gray code converter, purely combinational.
module binary2gray #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/wr_ptr_full_ctrl_gray2bin.sv
// Gray to binary converter: XOR prefix chain running down from the MSB.
module gray2binary #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  assign bin_o[WIDTH-1] = gray_i[WIDTH-1];

  for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_chain
    assign bin_o[i] = bin_o[i+1] ^ gray_i[i];
  end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer controller of the async FIFO: push qualification, binary/Gray
// write pointer, and pessimistic full/almost-full/fill tracking against the synced read pointer.
module wr_ptr_full_ctrl
  import wr_ptr_full_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int unsigned ALMOST_FULL_THR = AF_THR_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  w_inc_i,
  input  logic [ADDR_WIDTH:0]   rd_gray_sync_i,
  output logic                  w_en_o,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   fill_level_o,
  output logic                  overflow_o
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray_full_cmp;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic          w_en;

  gray2binary #(.WIDTH(PW)) u_rd_g2b (
    .gray_i (rd_gray_sync_i),
    .bin_o  (rbin)
  );

  binary2gray #(.WIDTH(PW)) u_wr_b2g (
    .bin_i  (wbin_d),
    .gray_o (wgray_d)
  );

  assign w_en = w_inc_i & ~full_q & ~rst_i;

  // In Gray space, "one full lap ahead" means the top two bits inverted.
  assign rgray_full_cmp = {~rd_gray_sync_i[PW-1:PW-2], rd_gray_sync_i[PW-3:0]};

  always_comb begin
    wbin_d = wbin_q + PW'(w_en);
    fill_d = wbin_d - rbin;
    full_d = (wgray_d == rgray_full_cmp);
    af_d   = (fill_d >= PW'(ALMOST_FULL_THR));
    ovf_d  = w_inc_i & full_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_en_o        = w_en;
  assign w_addr_o      = wbin_q[ADDR_WIDTH-1:0];
  assign wr_gray_ptr_o = wgray_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;
  assign fill_level_o  = fill_q;
  assign overflow_o    = ovf_q;

endmodule
